cr16_control_fsm: RTL
=====================

// Module: cr16_control_fsm
// PURPOSE
//   Instruction sequencer and decoder that drives the dataPath register-file/ALU block.
//   Fetches 16-bit instructions over a valid/ready handshake and holds the PC.
//   Decodes each instruction into datapath controls: loadReg, readRegA/B, Imm, op, selectImm.
//   Latches the datapath flags and resolves conditional branches (Bcond).
// PARAMETERS
//   PC_WIDTH  16  width of program counter / instruction address
//   RESET_PC  0   PC value loaded on reset
// PORTS
//   CLK          in   1         clock, rising edge
//   CLR          in   1         reset, asynchronous, active-low
//   pc           out  PC_WIDTH  address of instruction being requested
//   instr        in   16        instruction word, valid with instr_valid
//   instr_valid  in   1         instruction source has instr for current pc
//   instr_ready  out  1         sequencer accepts instr this cycle
//   flags        in   5         datapath flags {C,L,F,Z,N} = flags[4:0]
//   loadReg      out  5         write select to datapath; MSB=1 disables write
//   readRegA     out  4         datapath read port A select (Rdest)
//   readRegB     out  4         datapath read port B select (Rsrc)
//   Imm          out  8         immediate to datapath (datapath sign-extends)
//   op           out  8         ALU operation code
//   selectImm    out  1         1 = B operand is Imm, 0 = register B
//   illegal      out  1         one-cycle pulse: undefined opcode executed as NOP
//   halted       out  1         HALT executed; sticky until reset
// BEHAVIOUR
//   Instruction format: [15:12] opcode, [11:8] Rdest/cond, [7:4] opext, [3:0] Rsrc; imm = [7:0].
//   States: FETCH -> EXEC -> FETCH; HALT is terminal.
//   FETCH: instr_ready=1; on instr_valid&instr_ready latch IR, go EXEC. Otherwise hold; no output change.
//   EXEC: instr_ready=0. Decoded controls are registered from IR and valid for exactly this one cycle.
//     Register file captures Z on the EXEC-ending edge. Throughput: 2 cycles per instruction.
//   Outside EXEC: loadReg=5'h10, selectImm=0, op=8'h00; readRegA/B, Imm hold their last values.
//   Decode rules (EXEC cycle):
//     RR, opcode 0000: op={4'h0,opext}, readRegA=Rdest, readRegB=Rsrc, selectImm=0, loadReg={0,Rdest}.
//     Imm ALU, opcode in {1,2,3,5,9,B,D}: op={opcode,4'h0}, selectImm=1, Imm=instr[7:0].
//       For these, readRegA=Rdest and loadReg={0,Rdest}.
//     Compare (RR opext 1011, or opcode 1011): identical except loadReg=5'h10 (no write).
//     Bcond, opcode 1100: loadReg=5'h10; cond=instr[11:8]; disp=sign-extended instr[7:0].
//     HALT, opcode 1111: loadReg=5'h10; set halted; go to HALT.
//     Any other opcode: NOP, loadReg=5'h10, illegal=1 for the EXEC cycle.
//   Flag latch flag_q: loaded from flags at end of EXEC for RR/Imm/compare only.
//     Bcond, NOP and HALT leave flag_q unchanged.
//   Branch conditions on flag_q:
//     EQ 0 Z=1; NE 1 Z=0; CS 2 C=1; CC 3 C=0; FS 4 F=1; FC 5 F=0.
//     GT 6 N=1; LE 7 N=0; HI 8 L=1; LS 9 L=0; UC E always; all others never.
//   PC update, at end of EXEC: taken branch -> pc+disp; otherwise pc+1.
//     Arithmetic is modulo 2^PC_WIDTH; wrap at all-ones to 0 with no flag.
//   HALT state: instr_ready=0, loadReg=5'h10, pc frozen; left only by reset.
//   Reset (CLR=0, async): state=FETCH, pc=RESET_PC, loadReg=5'h10.
//     Also cleared: readRegA/B=0, Imm=0, op=0, selectImm=0, illegal=0, halted=0, flag_q=0.
//     instr_ready=0 while CLR=0; becomes 1 in the first cycle after release.
//   Reset asserted mid-EXEC: loadReg goes to 5'h10 immediately and no register write occurs.
// TESTING
//   1. CLR=0 mid-run -> loadReg=5'h10, pc=0, instr_ready=0 at once; release -> next cycle ready=1.
//   2. pc=0, instr 16'h53FE (ADDI R3,#-2) -> EXEC: readRegA=3, op=8'h50, selectImm=1.
//        Also Imm=8'hFE, loadReg=5'h03; then pc=1.
//   3. instr 16'h0152 (RR opext 5, R1,R2) -> op=8'h05, readRegA=1, readRegB=2.
//        Also selectImm=0, loadReg=5'h01.
//   4. CMP with flags=5'b00010, then at pc=5 instr 16'hC0FC (BEQ -4) -> pc=1, loadReg=5'h10.
//        Repeat with Z=0 -> pc=6.
//   5. instr_valid low 3 cycles in FETCH -> instr_ready=1, pc unchanged, loadReg=5'h10 throughout.
//   6. instr 16'hF000 -> halted=1, instr_ready=0 for 10+ cycles. Opcode 16'h7000 -> illegal pulse, pc+1.

Source files
------------

// File: rtl/cr16_control_fsm_if.sv
// cr16_control_fsm_if: fetch handshake, datapath flags and decoded datapath controls
// of the CR16 sequencer. The master side is the sequencer.
interface cr16_control_fsm_if #(
    parameter int PC_WIDTH = 16
);
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         instr;
    logic                instr_valid;
    logic                instr_ready;
    logic [4:0]          flags;
    logic [4:0]          load_reg;
    logic [3:0]          read_reg_a;
    logic [3:0]          read_reg_b;
    logic [7:0]          imm;
    logic [7:0]          op;
    logic                select_imm;
    logic                illegal;
    logic                halted;

    modport master (
        output pc, instr_ready, load_reg, read_reg_a, read_reg_b, imm, op, select_imm,
               illegal, halted,
        input  instr, instr_valid, flags
    );

    modport slave (
        input  pc, instr_ready, load_reg, read_reg_a, read_reg_b, imm, op, select_imm,
               illegal, halted,
        output instr, instr_valid, flags
    );
endinterface

// File: rtl/cr16_control_fsm.sv
// cr16_control_fsm: CR16 instruction sequencer/decoder; fetches over valid/ready,
// drives registered datapath controls for one EXEC cycle and resolves branches.
module cr16_control_fsm #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                rst_n,
    cr16_control_fsm_if.master bus
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t              state, state_d;
    logic [PC_WIDTH-1:0] pc, pc_d, disp;
    logic [15:0]         ir, ir_d, cond_met;
    logic [4:0]          flag_q, flag_d, load_reg, load_d;
    logic [3:0]          ra, ra_d, rb, rb_d;
    logic [7:0]          imm, imm_d, op, op_d;
    logic                sel, sel_d, illegal, illegal_d, halted, halted_d;
    logic [3:0]          opc, rd, ox, rs;
    logic                is_rr, is_imm, is_alu, is_cmp, taken;

    function automatic logic imm_class(input logic [3:0] o);
        return o inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    endfunction

    assign {opc, rd, ox, rs} = bus.instr;
    assign is_rr  = opc == 4'h0;
    assign is_imm = imm_class(opc);
    assign is_alu = is_rr || is_imm;
    assign is_cmp = (is_rr && ox == 4'hB) || opc == 4'hB;

    // Condition table indexed by cond; flag_q = {C,L,F,Z,N}
    assign cond_met = {1'b0, 1'b1, 4'b0000,
                       ~flag_q[3], flag_q[3], ~flag_q[0], flag_q[0],
                       ~flag_q[2], flag_q[2], ~flag_q[4], flag_q[4],
                       ~flag_q[1], flag_q[1]};
    assign taken = ir[15:12] == 4'hC && cond_met[ir[11:8]];
    assign disp  = {{(PC_WIDTH-8){ir[7]}}, ir[7:0]};

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        ir_d      = ir;
        flag_d    = flag_q;
        load_d    = 5'h10;
        op_d      = 8'h00;
        sel_d     = 1'b0;
        illegal_d = 1'b0;
        ra_d      = ra;
        rb_d      = rb;
        imm_d     = imm;
        halted_d  = halted;
        if (state == FETCH && bus.instr_valid) begin
            state_d   = EXEC;
            ir_d      = bus.instr;
            load_d    = is_alu && !is_cmp ? {1'b0, rd} : 5'h10;
            op_d      = is_rr ? {4'h0, ox} : is_imm ? {opc, 4'h0} : 8'h00;
            sel_d     = is_imm;
            ra_d      = is_alu ? rd : ra;
            rb_d      = is_rr ? rs : rb;
            imm_d     = is_imm ? bus.instr[7:0] : imm;
            illegal_d = !is_alu && opc != 4'hC && opc != 4'hF;
        end else if (state == EXEC) begin
            state_d  = ir[15:12] == 4'hF ? HALT : FETCH;
            halted_d = halted || ir[15:12] == 4'hF;
            flag_d   = ir[15:12] == 4'h0 || imm_class(ir[15:12]) ? bus.flags : flag_q;
            pc_d     = taken ? pc + disp : pc + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            flag_q   <= '0;
            load_reg <= 5'h10;
            op       <= '0;
            sel      <= 1'b0;
            illegal  <= 1'b0;
            ra       <= '0;
            rb       <= '0;
            imm      <= '0;
            halted   <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            ir       <= ir_d;
            flag_q   <= flag_d;
            load_reg <= load_d;
            op       <= op_d;
            sel      <= sel_d;
            illegal  <= illegal_d;
            ra       <= ra_d;
            rb       <= rb_d;
            imm      <= imm_d;
            halted   <= halted_d;
        end
    end

    assign bus.pc          = pc;
    assign bus.instr_ready = state == FETCH && rst_n;
    assign bus.load_reg    = load_reg;
    assign bus.read_reg_a  = ra;
    assign bus.read_reg_b  = rb;
    assign bus.imm         = imm;
    assign bus.op          = op;
    assign bus.select_imm  = sel;
    assign bus.illegal     = illegal;
    assign bus.halted      = halted;
endmodule
